// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: EX-stage ALU controller with an iterative multiply/divide unit.
//   Decodes ALUOp/funct into a 4-bit ALU control code (combinational), and runs
//   mult/multu/div/divu over DATA_W iterations, writing HI/LO at completion.
// Ports:
//   clk_i, rst_i (async, active low)     : clock and reset
//   valid_i, ALUOp_i, funct_i            : instruction in EX
//   src1_i, src2_i                       : rs / rt operands
//   ALUCtrl_o                            : ALU control code
//   mdu_sel_o, result_o                  : mfhi/mflo select and readout value
//   busy_o, stall_o, done_o              : MDU handshake to the pipeline
//   hi_o, lo_o                           : HI / LO registers
module alu_mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              mdu_sel_o,
    output logic [DATA_W-1:0] result_o,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_FIX = 2'd2} state_t;

    // Two's-complement negate when n is set.
    function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] v);
        return n ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_mcand;   // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   r_acc_hi;  // product upper half / partial remainder
    logic [DATA_W-1:0]   r_acc_lo;  // multiplier -> product lower half / dividend -> quotient
    logic                r_is_div, r_neg_q, r_neg_r, r_div0;
    logic [DATA_W-1:0]   r_hi, r_lo;
    logic                r_done;

    logic                w_rtype, w_is_mdu, w_is_mfhi, w_is_mflo, w_accept;
    logic                w_signed, w_neg1, w_neg2;
    logic [DATA_W-1:0]   w_mag1, w_mag2;
    logic [DATA_W:0]     w_sum, w_shift, w_diff;
    logic [DATA_W-1:0]   w_step_hi, w_step_lo;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_q, w_r, w_fix_hi, w_fix_lo;
    logic                w_cnt_last;

    assign w_rtype   = (ALUOp_i == 3'b010);
    assign w_is_mdu  = w_rtype && (funct_i[5:2] == 4'b0110);   // funct 24..27
    assign w_is_mfhi = w_rtype && (funct_i == 6'd16);
    assign w_is_mflo = w_rtype && (funct_i == 6'd18);
    assign w_accept  = valid_i && w_is_mdu && (r_state == ST_IDLE);
    // funct[0]=0 selects the signed variants (mult 24, div 26); funct[1] selects divide
    assign w_signed  = ~funct_i[0];
    assign w_neg1    = w_signed && src1_i[DATA_W-1];
    assign w_neg2    = w_signed && src2_i[DATA_W-1];
    assign w_mag1    = neg_if(w_neg1, src1_i);
    assign w_mag2    = neg_if(w_neg2, src2_i);
    assign w_cnt_last = (r_cnt == CNT_W'(DATA_W - 1));

    // ALU control decode, purely combinational.
    always_comb begin
        ALUCtrl_o = 4'b0000;
        case (ALUOp_i)
            3'b010: begin
                case (funct_i)
                    6'd32:   ALUCtrl_o = 4'b0010;
                    6'd34:   ALUCtrl_o = 4'b0110;
                    6'd36:   ALUCtrl_o = 4'b0000;
                    6'd37:   ALUCtrl_o = 4'b0001;
                    6'd42:   ALUCtrl_o = 4'b0111;
                    default: ALUCtrl_o = 4'b0000;
                endcase
            end
            3'b001:  ALUCtrl_o = 4'b0110;
            3'b101:  ALUCtrl_o = 4'b0010;
            3'b110:  ALUCtrl_o = 4'b0111;
            default: ALUCtrl_o = 4'b0000;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide step.
    always_comb begin
        w_sum     = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : {(DATA_W+1){1'b0}});
        w_shift   = {r_acc_hi, r_acc_lo[DATA_W-1]};
        // partial remainder stays below the divisor, so bit DATA_W is a clean borrow flag
        w_diff    = w_shift - {1'b0, r_mcand};
        w_step_hi = w_sum[DATA_W:1];
        w_step_lo = {w_sum[0], r_acc_lo[DATA_W-1:1]};
        if (r_is_div) begin
            if (!w_diff[DATA_W]) begin
                w_step_hi = w_diff[DATA_W-1:0];
                w_step_lo = {r_acc_lo[DATA_W-2:0], 1'b1};
            end else begin
                w_step_hi = w_shift[DATA_W-1:0];
                w_step_lo = {r_acc_lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            w_step_hi = w_sum[DATA_W:1];
            w_step_lo = {w_sum[0], r_acc_lo[DATA_W-1:1]};
        end
    end

    // Sign correction of the final magnitudes. A zero divisor leaves the dividend
    // magnitude in the remainder, so re-applying src1's sign restores src1 raw.
    always_comb begin
        w_prod = {r_acc_hi, r_acc_lo};
        if (r_neg_q) begin
            w_prod = ~{r_acc_hi, r_acc_lo} + {{(2*DATA_W-1){1'b0}}, 1'b1};
        end else begin
            w_prod = {r_acc_hi, r_acc_lo};
        end
        w_q = neg_if(r_neg_q, r_acc_lo);
        w_r = neg_if(r_neg_r, r_acc_hi);
        if (r_is_div) begin
            w_fix_hi = w_r;
            w_fix_lo = r_div0 ? {DATA_W{1'b1}} : w_q;
        end else begin
            w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
            w_fix_lo = w_prod[DATA_W-1:0];
        end
    end

    // FSM next-state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_CALC;
                else          w_state_nxt = ST_IDLE;
            end
            ST_CALC: begin
                if (w_cnt_last) w_state_nxt = ST_FIX;
                else            w_state_nxt = ST_CALC;
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // MDU datapath: operand latch, iteration, HI/LO write and done pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_mcand  <= {DATA_W{1'b0}};
            r_acc_hi <= {DATA_W{1'b0}};
            r_acc_lo <= {DATA_W{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= {DATA_W{1'b0}};
            r_lo     <= {DATA_W{1'b0}};
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= funct_i[1];
                        r_neg_q  <= w_neg1 ^ w_neg2;
                        r_neg_r  <= w_neg1;
                        r_div0   <= (src2_i == {DATA_W{1'b0}});
                        r_cnt    <= {CNT_W{1'b0}};
                        r_mcand  <= funct_i[1] ? w_mag2 : w_mag1;
                        r_acc_lo <= funct_i[1] ? w_mag1 : w_mag2;
                        r_acc_hi <= {DATA_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_FIX: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy_o    = (r_state != ST_IDLE);
    assign stall_o   = valid_i && busy_o && (w_is_mdu || w_is_mfhi || w_is_mflo);
    assign done_o    = r_done;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign mdu_sel_o = w_is_mfhi || w_is_mflo;
    assign result_o  = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : {DATA_W{1'b0}});
endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl (DATA_W=32): directed vectors, with a
// scoreboard queue of expected HI/LO/completion cycle popped by a done_o monitor.
module tb_alu_mdu_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [2:0]    aluop = 3'b000;
    logic [5:0]    funct = 6'd0;
    logic [W-1:0]  src1 = '0, src2 = '0;
    logic [3:0]    alu_ctrl;
    logic          mdu_sel, busy, stall, done;
    logic [W-1:0]  result, hi, lo;

    alu_mdu_ctrl #(.DATA_W(W)) dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ALUOp_i(aluop),
        .funct_i(funct), .src1_i(src1), .src2_i(src2), .ALUCtrl_o(alu_ctrl),
        .mdu_sel_o(mdu_sel), .result_o(result), .busy_o(busy), .stall_o(stall),
        .done_o(done), .hi_o(hi), .lo_o(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending op (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_hi", {32'd0, hi}, {32'd0, e.hi});
                chk("sb_lo", {32'd0, lo}, {32'd0, e.lo});
                chk("sb_latency", 64'(cyc), 64'(e.done_cyc));
            end
        end
    end

    // Issue one MDU op at a negedge; returns at the next negedge with valid low.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo);
        exp_t e;
        valid = 1'b1; aluop = 3'b010; funct = f; src1 = a; src2 = b;
        e.hi = ehi; e.lo = elo; e.done_cyc = cyc + W + 2;
        sb_q.push_back(e);
        @(negedge clk);
        valid = 1'b0; aluop = 3'b000; funct = 6'd0;
        src1 = ~a; src2 = ~b;   // operands must be ignored after acceptance
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // {ALUOp, funct, expected ALUCtrl}
    logic [12:0] dv [11] = '{
        {3'b010, 6'd34, 4'b0110}, {3'b010, 6'd32, 4'b0010}, {3'b010, 6'd36, 4'b0000},
        {3'b010, 6'd37, 4'b0001}, {3'b010, 6'd42, 4'b0111}, {3'b010, 6'd0,  4'b0000},
        {3'b001, 6'd5,  4'b0110}, {3'b101, 6'd0,  4'b0010}, {3'b110, 6'd9,  4'b0111},
        {3'b011, 6'd24, 4'b0000}, {3'b000, 6'd32, 4'b0000}
    };

    initial begin
        int n;
        logic [12:0] v;

        // Reset state, with an MDU op presented while reset is held.
        valid = 1'b1; aluop = 3'b010; funct = 6'd24; src1 = 32'd3; src2 = 32'd4;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Combinational decode table.
        for (int i = 0; i < 11; i++) begin
            v = dv[i];
            valid = 1'b1; aluop = v[12:10]; funct = v[9:4];
            #1;
            chk($sformatf("decode_%0d", i), {60'd0, alu_ctrl}, {60'd0, v[3:0]});
            @(negedge clk);
            chk($sformatf("decode_nobusy_%0d", i), {63'd0, busy}, 64'd0);
        end
        valid = 1'b0; aluop = 3'b000; funct = 6'd0;
        @(negedge clk);

        // multu all-ones squared, counting busy cycles.
        issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(n), 64'd33);
        chk("done_after_busy", {63'd0, done}, 64'd1);
        drain();

        issue(6'd24, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1); drain();
        issue(6'd24, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0); drain();
        issue(6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD); drain();
        issue(6'd27, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF); drain();
        issue(6'd26, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF); drain();
        issue(6'd27, 32'd100, 32'd7, 32'd2, 32'd14); drain();
        issue(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000); drain();

        // Stall handshake during a busy multu (HI=0, LO=0x80000000 beforehand).
        issue(6'd25, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0);
        valid = 1'b1; aluop = 3'b010; funct = 6'd32;
        #1 chk("stall_nonmdu", {63'd0, stall}, 64'd0);
        @(negedge clk);
        funct = 6'd27; src1 = 32'd9; src2 = 32'd3;
        #1 chk("stall_divu", {63'd0, stall}, 64'd1);
        @(negedge clk);
        funct = 6'd16;
        #1 chk("stall_mfhi", {63'd0, stall}, 64'd1);
        chk("busy_hilo_held", {hi, lo}, {32'h0, 32'h8000_0000});
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
        chk("done_mfhi_result", {32'd0, result}, {32'd0, 32'h0000_0003});
        chk("done_mfhi_stall", {63'd0, stall}, 64'd0);
        chk("done_mfhi_sel", {63'd0, mdu_sel}, 64'd1);
        funct = 6'd18;
        #1 chk("mflo_result", {32'd0, result}, 64'd0);
        @(negedge clk);
        valid = 1'b0; aluop = 3'b000; funct = 6'd0;
        drain();

        // Reset in the middle of a div: abandoned, no done pulse.
        issue(6'd26, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("midrst_no_done", 64'(n), 64'd0);
        issue(6'd24, 32'd2, 32'd3, 32'd0, 32'd6); drain();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_mdu_ctrl.md
Name: alu_mdu_ctrl

Overview:
- Second-generation ALU controller for the MIPS datapath.
- Keeps the single-cycle ALUOp/funct decode to a 4-bit ALU control code.
- Adds a parametrised iterative multiply/divide unit (MDU) for mult, multu, div and divu, with HI/LO registers, mfhi/mflo readout and a stall handshake to the pipeline/control unit.
- Sits between Decoder and ALU in the EX stage.

Parameters:
- DATA_W, 32: operand/HI/LO width; even, >= 4.
- CNT_W, $clog2(DATA_W+1): iteration counter width; derived, not overridden.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- valid_i  input  1  instruction in EX is valid this cycle
- ALUOp_i  input  3  main-decoder ALU op class
- funct_i  input  6  R-type funct field
- src1_i  input  DATA_W  rs operand (dividend/multiplicand)
- src2_i  input  DATA_W  rt operand (divisor/multiplier)
- ALUCtrl_o  output  4  ALU control code
- mdu_sel_o  output  1  current instruction is mfhi/mflo; result_o replaces ALU result
- result_o  output  DATA_W  HI for mfhi, LO for mflo, else 0
- busy_o  output  1  MDU iterating (state != IDLE)
- stall_o  output  1  freeze upstream this cycle
- done_o  output  1  one-cycle pulse; new HI/LO visible this cycle
- hi_o  output  DATA_W  HI register
- lo_o  output  DATA_W  LO register

Behaviour:
- Decode (combinational, 0 latency, independent of valid_i):
  - ALUOp 010, funct 32/34/36/37/42 -> 0010/0110/0000/0001/0111.
  - ALUOp 010, any other funct -> 0000.
  - ALUOp 001 -> 0110; 101 -> 0010; 110 -> 0111; any other ALUOp -> 0000.
- MDU ops: ALUOp 010 with funct 24 mult, 25 multu, 26 div, 27 divu. Readout ops: funct 16 mfhi, 18 mflo.
- Reset (rst_i low, async): state IDLE, HI=LO=0, counter 0, done_o=0, internal operand/accumulator registers 0. busy_o and stall_o read 0 while reset is held. An operation in progress is abandoned with no done pulse.
- FSM IDLE -> CALC -> FIX -> IDLE:
  - IDLE: on a clock edge with valid_i=1 and an MDU op, latch the operation type and the operand magnitudes (absolute values for signed ops, raw values for unsigned), latch result sign flags, clear the counter; go to CALC.
  - CALC: one bit per cycle for exactly DATA_W cycles.
    - Multiply: shift-add of magnitudes into a 2*DATA_W product.
    - Divide: restoring division giving quotient and remainder magnitudes.
    - Leave CALC when the counter reaches DATA_W-1.
  - FIX (1 cycle): apply sign correction and write HI/LO at the edge leaving FIX. done_o is registered high for the following cycle, concurrent with the new HI/LO and busy_o=0.
- Latency: acceptance edge E0; HI/LO updated at edge E(DATA_W+1); busy_o high for DATA_W+1 cycles.
- Signed rules:
  - Product is negated when exactly one operand is negative.
  - Quotient sign = sign(src1) XOR sign(src2); remainder sign = sign(src1).
  - mult/multu: HI = upper half, LO = lower half.
  - div/divu: LO = quotient, HI = remainder.
- Division by zero (signed or unsigned): LO = all ones, HI = src1 raw; same latency.
- Signed MIN / -1: LO = MIN, HI = 0, falls out of the magnitude algorithm.
- stall_o = valid_i and (busy_o or done_o=0 irrelevant) restricted to busy_o=1 and an MDU or mfhi/mflo op: it is 1 only while busy_o=1 and the current instruction is an MDU or readout op. MDU or readout ops presented while busy are not accepted. Non-MDU instructions never stall.
- mfhi/mflo with busy_o=0 read the current HI/LO combinationally. In the done_o cycle they return the new values.
- Operands are sampled only at acceptance; src1_i/src2_i changes during CALC have no effect.

Test Plan:
- ALUOp 010 funct 34 -> ALUCtrl_o 0110; ALUOp 101 -> 0010; ALUOp 011 -> 0000, busy_o stays 0.
- DATA_W=32, multu 0xFFFFFFFF x 0xFFFFFFFF -> busy_o high 33 cycles, then done_o pulse, HI=0xFFFFFFFE, LO=0x00000001.
- mult -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; mult 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> LO=0xFFFFFFFF, HI=0x00000007; div 0x80000000/-1 -> LO=0x80000000, HI=0.
- During a busy multu, present divu then mfhi -> stall_o=1 both cycles, HI/LO unchanged. In the done_o cycle, mfhi -> result_o = new HI, stall_o=0, mdu_sel_o=1.
- Pulse rst_i low at cycle 10 of a div -> busy_o, HI, LO clear immediately, no done_o; a following mult 2x3 completes normally with LO=6.
